// File: rtl/hazard_detection_unit.sv
//=============================================================================
// Module      : hazard_detection_unit
// Description : Load-use stall, EX branch/jump redirect and DMEM freeze control
//               for the pipeline flush logic. Optional macro: HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module hazard_detection_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int LU_STALL_CYCLES = 1,
    parameter int STALL_CNT_W     = 32
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [REG_ADDR_W-1:0] ID_RS1,
    input  logic [REG_ADDR_W-1:0] ID_RS2,
    input  logic                  ID_USE_RS1,
    input  logic                  ID_USE_RS2,
    input  logic [REG_ADDR_W-1:0] EX_RD,
    input  logic                  EX_MEM_READ,
    input  logic                  EX_REG_WRITE,
    input  logic                  EX_BJ_TAKEN,
    input  logic                  DMEM_BUSY,
    output logic                  SIG_HAZARDS_D,
    output logic                  SIG_BJ,
    output logic                  PC_HOLD,
    output logic                  PIPE_FREEZE,
    output logic [1:0]            HZ_STATE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] STALL_CNT,
    output logic [STALL_CNT_W-1:0] FLUSH_CNT
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] LU_REMAIN_INIT = 2'(LU_STALL_CYCLES - 1);

    generate
        if (LU_STALL_CYCLES < 1 || LU_STALL_CYCLES > 3) begin : g_bad_lu_stall_cycles
            $error("hazard_detection_unit: LU_STALL_CYCLES must be 1..3");
        end
        if (STALL_CNT_W < 1) begin : g_bad_stall_cnt_w
            $error("hazard_detection_unit: STALL_CNT_W must be >= 1");
        end
    endgenerate

    hz_state_e  state_q, state_d;
    hz_state_e  ret_state_q, ret_state_d;
    hz_state_e  eval_state;
    logic [1:0] remain_q, remain_d;
    logic       lu_hit;
    logic       hz_int, bj_int, freeze_int;

    assign lu_hit = EX_MEM_READ && EX_REG_WRITE && (EX_RD != '0) &&
                    ((ID_USE_RS1 && (ID_RS1 == EX_RD)) ||
                     (ID_USE_RS2 && (ID_RS2 == EX_RD)));

    // On freeze release the interrupted state is evaluated directly: no dead cycle.
    assign eval_state = (state_q == MEM_WAIT) ? ret_state_q : state_q;

    always_comb begin
        state_d     = state_q;
        ret_state_d = ret_state_q;
        remain_d    = remain_q;
        hz_int      = 1'b0;
        bj_int      = 1'b0;
        freeze_int  = 1'b0;
        if (DMEM_BUSY) begin
            freeze_int = 1'b1;
            state_d    = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                ret_state_d = state_q;
            end
        end else begin
            case (eval_state)
                LU_STALL: begin
                    if (EX_BJ_TAKEN) begin
                        bj_int   = 1'b1;
                        remain_d = 2'd0;
                        state_d  = RUN;
                    end else begin
                        hz_int   = 1'b1;
                        remain_d = remain_q - 2'd1;
                        state_d  = (remain_q == 2'd1) ? RUN : LU_STALL;
                    end
                end
                default: begin
                    state_d = RUN;
                    if (EX_BJ_TAKEN) begin
                        bj_int = 1'b1;
                    end else if (lu_hit) begin
                        hz_int = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            remain_d = LU_REMAIN_INIT;
                            state_d  = LU_STALL;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= RUN;
            ret_state_q <= RUN;
            remain_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            ret_state_q <= ret_state_d;
            remain_q    <= remain_d;
        end
    end

    assign SIG_HAZARDS_D = RESET && hz_int;
    assign SIG_BJ        = RESET && bj_int;
    assign PIPE_FREEZE   = RESET && freeze_int;
    assign PC_HOLD       = SIG_HAZARDS_D || PIPE_FREEZE;
    assign HZ_STATE      = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STALL_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (SIG_HAZARDS_D && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (SIG_BJ && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
    assign FLUSH_CNT = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
//=============================================================================
// Module      : tb_hazard_detection_unit
// Description : Directed bench for hazard_detection_unit, one instance with a
//               1-cycle and one with a 3-cycle load-use stall.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_mem_read, ex_reg_write, ex_bj_taken, dmem_busy;

    logic       hz1, bj1, pch1, frz1;
    logic [1:0] st1;
    logic       hz3, bj3, pch3, frz3;
    logic [1:0] st3;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_CNT_EN
    logic [3:0]  scnt1, fcnt1;
    logic [31:0] scnt3, fcnt3;
`endif

    hazard_detection_unit #(.REG_ADDR_W(5), .LU_STALL_CYCLES(1), .STALL_CNT_W(4)) u_dut1 (
        .CLK(clk), .RESET(rst_n),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USE_RS1(id_use_rs1), .ID_USE_RS2(id_use_rs2),
        .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .EX_REG_WRITE(ex_reg_write),
        .EX_BJ_TAKEN(ex_bj_taken), .DMEM_BUSY(dmem_busy),
        .SIG_HAZARDS_D(hz1), .SIG_BJ(bj1), .PC_HOLD(pch1), .PIPE_FREEZE(frz1), .HZ_STATE(st1)
`ifdef HAZARD_PERF_CNT_EN
        , .STALL_CNT(scnt1), .FLUSH_CNT(fcnt1)
`endif
    );

    hazard_detection_unit #(.REG_ADDR_W(5), .LU_STALL_CYCLES(3), .STALL_CNT_W(32)) u_dut3 (
        .CLK(clk), .RESET(rst_n),
        .ID_RS1(id_rs1), .ID_RS2(id_rs2), .ID_USE_RS1(id_use_rs1), .ID_USE_RS2(id_use_rs2),
        .EX_RD(ex_rd), .EX_MEM_READ(ex_mem_read), .EX_REG_WRITE(ex_reg_write),
        .EX_BJ_TAKEN(ex_bj_taken), .DMEM_BUSY(dmem_busy),
        .SIG_HAZARDS_D(hz3), .SIG_BJ(bj3), .PC_HOLD(pch3), .PIPE_FREEZE(frz3), .HZ_STATE(st3)
`ifdef HAZARD_PERF_CNT_EN
        , .STALL_CNT(scnt3), .FLUSH_CNT(fcnt3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = 5'd0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        ex_bj_taken = 1'b0; dmem_busy = 1'b0;
    endtask

    // EX: lw x5 ; ID: add x6, x5, x1
    task automatic set_lu();
        id_rs1 = 5'd5; id_rs2 = 5'd1; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
        ex_rd = 5'd5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_in();
        set_lu();
        #2;
        chk("rst_hz1", hz1, 1'b0);
        chk("rst_pch3", pch3, 1'b0);
        chk("rst_st3", st3, 2'd0);
        tick();
        rst_n = 1'b1;
        clear_in();
        tick();

        // 1/2: load-use stall length 1 and 3
        set_lu();
        mid();
        chk("t1_hz1", hz1, 1'b1);
        chk("t1_pch1", pch1, 1'b1);
        chk("t2_hz3_c0", hz3, 1'b1);
        chk("t2_st3_c0", st3, 2'd0);
        tick();
        clear_in();
        mid();
        chk("t1_hz1_after", hz1, 1'b0);
        chk("t1_pch1_after", pch1, 1'b0);
        chk("t2_hz3_c1", hz3, 1'b1);
        chk("t2_st3_c1", st3, 2'd1);
        tick();
        mid();
        chk("t2_hz3_c2", hz3, 1'b1);
        chk("t2_st3_c2", st3, 2'd1);
        tick();
        mid();
        chk("t2_hz3_c3", hz3, 1'b0);
        chk("t2_st3_c3", st3, 2'd0);
        tick();

        // 3: x0 never hazards; BJ beats load-use
        id_rs1 = 5'd0; id_use_rs1 = 1'b1; ex_rd = 5'd0; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
        mid();
        chk("t3_x0_hz1", hz1, 1'b0);
        chk("t3_x0_hz3", hz3, 1'b0);
        tick();
        set_lu();
        ex_bj_taken = 1'b1;
        mid();
        chk("t3_bj1", bj1, 1'b1);
        chk("t3_bj_hz1", hz1, 1'b0);
        chk("t3_bj3", bj3, 1'b1);
        chk("t3_bj_hz3", hz3, 1'b0);
        tick();
        clear_in();
        mid();
        chk("t3_st3_run", st3, 2'd0);
        chk("t3_bj1_clr", bj1, 1'b0);
        tick();

        // BJ aborts a stall in progress
        set_lu();
        tick();
        clear_in();
        ex_bj_taken = 1'b1;
        mid();
        chk("abort_st3", st3, 2'd1);
        chk("abort_bj3", bj3, 1'b1);
        chk("abort_hz3", hz3, 1'b0);
        tick();
        clear_in();
        mid();
        chk("abort_st3_run", st3, 2'd0);
        chk("abort_hz3_done", hz3, 1'b0);
        tick();

        // 4: DMEM_BUSY for 4 cycles in the 2nd stall cycle
        set_lu();
        mid();
        chk("t4_hz3_c1", hz3, 1'b1);
        tick();
        clear_in();
        dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) ex_bj_taken = 1'b1;
            else        ex_bj_taken = 1'b0;
            mid();
            chk("t4_frz3", frz3, 1'b1);
            chk("t4_frz_hz3", hz3, 1'b0);
            chk("t4_frz_bj3", bj3, 1'b0);
            chk("t4_frz_pch3", pch3, 1'b1);
            chk("t4_frz_st3", st3, (i == 0) ? 2'd1 : 2'd2);
            tick();
        end
        clear_in();
        mid();
        chk("t4_rel_st3", st3, 2'd2);
        chk("t4_rel_frz3", frz3, 1'b0);
        chk("t4_rel_hz3", hz3, 1'b1);
        chk("t4_rel_frz1", frz1, 1'b0);
        tick();
        mid();
        chk("t4_c3_st3", st3, 2'd1);
        chk("t4_c3_hz3", hz3, 1'b1);
        tick();
        mid();
        chk("t4_end_st3", st3, 2'd0);
        chk("t4_end_hz3", hz3, 1'b0);
        tick();

        // 5: async reset in the middle of a stall
        set_lu();
        tick();
        clear_in();
        mid();
        chk("t5_pre_st3", st3, 2'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_hz3", hz3, 1'b0);
        chk("t5_rst_pch3", pch3, 1'b0);
        chk("t5_rst_st3", st3, 2'd0);
        tick();
        rst_n = 1'b1;
        mid();
        chk("t5_post_hz3", hz3, 1'b0);
        chk("t5_post_st3", st3, 2'd0);
        tick();
        mid();
        chk("t5_post2_hz3", hz3, 1'b0);
        tick();

`ifdef HAZARD_PERF_CNT_EN
        // 6: saturating 4-bit stall counter
        rst_n = 1'b0;
        #1;
        chk("t6_rst_scnt1", scnt1, 4'd0);
        tick();
        rst_n = 1'b1;
        set_lu();
        for (int i = 0; i < 20; i++) tick();
        clear_in();
        mid();
        chk("t6_scnt1", scnt1, 4'd15);
        chk("t6_fcnt1", fcnt1, 4'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

`default_nettype wire
